// File: rtl/vga_stream_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_stream_timing_pkg
// Shared definitions for the VGA stream timing block:
//   - 640x480@60 default timing constants (pixels / lines)
//   - counter width used by the h/v counters
//   - FSM state encoding
//   - RGB565 field positions and the RGB565 -> RGB888 expansion helper
// -----------------------------------------------------------------------------
package vga_stream_timing_pkg;

  // Counter width; covers totals up to 4095 pixels or lines.
  localparam int CNT_W = 12;

  // Pixel widths on the input stream and on the colour output.
  localparam int PIX_W = 16;
  localparam int RGB_W = 24;

  // 640x480@60 timing (25.175 MHz pixel clock).
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // RGB565 field positions inside pix_data.
  localparam int R5_MSB = 15;
  localparam int R5_LSB = 11;
  localparam int G6_MSB = 10;
  localparam int G6_LSB = 5;
  localparam int B5_MSB = 4;
  localparam int B5_LSB = 0;

  // Streaming FSM: SYNC_WAIT idles the pixel path, RUN streams whole frames.
  typedef enum logic [0:0] {
    SYNC_WAIT = 1'b0,
    RUN       = 1'b1
  } vga_state_e;

  // Expand RGB565 to RGB888 by replicating the field MSBs into the new LSBs,
  // so full-scale inputs map to 8'hFF and zero stays zero.
  function automatic logic [RGB_W-1:0] rgb565_expand(input logic [PIX_W-1:0] pix);
    logic [4:0] r5_s;
    logic [5:0] g6_s;
    logic [4:0] b5_s;
    r5_s = pix[R5_MSB:R5_LSB];
    g6_s = pix[G6_MSB:G6_LSB];
    b5_s = pix[B5_MSB:B5_LSB];
    return {r5_s, r5_s[4:2], g6_s, g6_s[5:4], b5_s, b5_s[4:2]};
  endfunction

endpackage

// File: rtl/vga_stream_timing_if.sv
// -----------------------------------------------------------------------------
// vga_stream_timing_if
// Pixel stream from the upstream frame FIFO into the timing block.
//   pix_data  : RGB565 pixel
//   pix_valid : pix_data is valid (driven by the FIFO side)
//   pix_ready : the timing block consumes pix_data this cycle
// Modports: master = FIFO / source side, slave = timing block side.
// -----------------------------------------------------------------------------
interface vga_stream_timing_if;
  import vga_stream_timing_pkg::*;

  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             pix_ready;

  modport master (
    output pix_data,
    output pix_valid,
    input  pix_ready
  );

  modport slave (
    input  pix_data,
    input  pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/vga_stream_timing_counter.sv
// -----------------------------------------------------------------------------
// vga_timing_counter
// Horizontal/vertical raster counters with region decode.
//   pclk      : pixel clock
//   rst_n     : active-low reset (already synchronised by the parent)
//   active    : current position is inside the visible area
//   in_hsync  : current pixel lies in the horizontal sync pulse
//   in_vsync  : current line lies in the vertical sync pulse
//   at_origin : counters at (0,0), first pixel of a frame
//   at_end    : counters at (H_TOTAL-1, V_TOTAL-1), last pixel of a frame
// All decode outputs describe the current counter state (combinational).
// -----------------------------------------------------------------------------
module vga_timing_counter
  import vga_stream_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic pclk,
  input  logic rst_n,
  output logic active,
  output logic in_hsync,
  output logic in_vsync,
  output logic at_origin,
  output logic at_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [CNT_W-1:0] h_cnt_r;
  logic [CNT_W-1:0] v_cnt_r;

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_r <= ZERO_C;
      v_cnt_r <= ZERO_C;
    end else if (h_cnt_r == H_LAST_C) begin
      h_cnt_r <= ZERO_C;
      if (v_cnt_r == V_LAST_C) begin
        v_cnt_r <= ZERO_C;
      end else begin
        v_cnt_r <= v_cnt_r + ONE_C;
      end
    end else begin
      h_cnt_r <= h_cnt_r + ONE_C;
      v_cnt_r <= v_cnt_r;
    end
  end

  assign active    = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
  assign in_hsync  = (h_cnt_r >= HS_BEG_C) && (h_cnt_r < HS_END_C);
  assign in_vsync  = (v_cnt_r >= VS_BEG_C) && (v_cnt_r < VS_END_C);
  assign at_origin = (h_cnt_r == ZERO_C) && (v_cnt_r == ZERO_C);
  assign at_end    = (h_cnt_r == H_LAST_C) && (v_cnt_r == V_LAST_C);

endmodule

// File: rtl/vga_stream_timing.sv
// -----------------------------------------------------------------------------
// vga_stream_timing
// Converts an RGB565 pixel stream into registered VGA/HDMI timing and RGB888.
//   pclk           : pixel clock, the only clock
//   rst_n          : async-assert active-low reset, release synchronised here
//   enable         : request to stream frames (sampled at frame boundaries)
//   pix            : slave side of the pixel stream (data/valid in, ready out)
//   out_vga_*      : registered colour, blank and sync, one cycle behind the
//                    counter state that produced them
//   frame_start    : one-cycle pulse with the first output pixel of a frame
//   underflow_cnt  : saturating count of active slots with no pixel available
// -----------------------------------------------------------------------------
module vga_stream_timing
  import vga_stream_timing_pkg::*;
#(
  parameter int              H_ACTIVE      = VGA_H_ACTIVE,
  parameter int              H_FP          = VGA_H_FP,
  parameter int              H_SYNC        = VGA_H_SYNC,
  parameter int              H_BP          = VGA_H_BP,
  parameter int              V_ACTIVE      = VGA_V_ACTIVE,
  parameter int              V_FP          = VGA_V_FP,
  parameter int              V_SYNC        = VGA_V_SYNC,
  parameter int              V_BP          = VGA_V_BP,
  parameter bit              SYNC_ACTIVE   = 1'b0,
  parameter logic [RGB_W-1:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  input  logic                 enable,
  vga_stream_timing_if.slave   pix,
  output logic [7:0]           out_vga_red,
  output logic [7:0]           out_vga_green,
  output logic [7:0]           out_vga_blue,
  output logic                 out_vga_blank,
  output logic                 out_vga_hsync,
  output logic                 out_vga_vsync,
  output logic                 frame_start,
  output logic [15:0]          underflow_cnt
);

  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;
  logic             active_s;
  logic             in_hsync_s;
  logic             in_vsync_s;
  logic             at_origin_s;
  logic             at_end_s;
  vga_state_e       state_r;
  vga_state_e       state_nxt_s;
  logic             run_s;
  logic             slot_live_s;
  logic [RGB_W-1:0] rgb_r;
  logic             blank_r;
  logic             hsync_r;
  logic             vsync_r;
  logic             frame_start_r;
  logic [15:0]      underflow_r;

  // Reset synchroniser: assertion passes straight through, release takes two pclk.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_counter (
    .pclk      (pclk),
    .rst_n     (rst_int_n_s),
    .active    (active_s),
    .in_hsync  (in_hsync_s),
    .in_vsync  (in_vsync_s),
    .at_origin (at_origin_s),
    .at_end    (at_end_s)
  );

  // FSM state register.
  always_ff @(posedge pclk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      state_r <= SYNC_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and run qualifier. The SYNC_WAIT->RUN decision taken at
  // (0,0) already applies to the (0,0) slot itself, so the first streamed
  // frame is always complete. Leaving RUN is only possible on the last pixel.
  always_comb begin
    state_nxt_s = state_r;
    run_s       = 1'b0;
    case (state_r)
      SYNC_WAIT: begin
        if (rst_int_n_s && at_origin_s && enable) begin
          state_nxt_s = RUN;
          run_s       = 1'b1;
        end else begin
          state_nxt_s = SYNC_WAIT;
          run_s       = 1'b0;
        end
      end
      RUN: begin
        run_s = 1'b1;
        if (at_end_s && !enable) begin
          state_nxt_s = SYNC_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = SYNC_WAIT;
        run_s       = 1'b0;
      end
    endcase
  end

  // A pixel slot is live when streaming and inside the visible area.
  assign slot_live_s   = run_s & active_s;
  assign pix.pix_ready = slot_live_s;

  // Timing outputs: blank, syncs and frame pulse, one cycle behind the counters.
  always_ff @(posedge pclk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      blank_r       <= 1'b1;
      hsync_r       <= ~SYNC_ACTIVE;
      vsync_r       <= ~SYNC_ACTIVE;
      frame_start_r <= 1'b0;
    end else begin
      blank_r       <= ~slot_live_s;
      hsync_r       <= in_hsync_s ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_r       <= in_vsync_s ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start_r <= run_s & at_origin_s;
    end
  end

  // Colour path: expanded pixel on a transfer, marker colour on a missed slot,
  // black everywhere else. A missed slot is dropped, never stalled.
  always_ff @(posedge pclk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      rgb_r <= 24'h000000;
    end else if (slot_live_s) begin
      if (pix.pix_valid) begin
        rgb_r <= rgb565_expand(pix.pix_data);
      end else begin
        rgb_r <= UNDERFLOW_RGB;
      end
    end else begin
      rgb_r <= 24'h000000;
    end
  end

  // Saturating count of live slots that found no valid pixel.
  always_ff @(posedge pclk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      underflow_r <= 16'h0000;
    end else if (slot_live_s && !pix.pix_valid && (underflow_r != 16'hFFFF)) begin
      underflow_r <= underflow_r + 16'h0001;
    end else begin
      underflow_r <= underflow_r;
    end
  end

  assign out_vga_red   = rgb_r[23:16];
  assign out_vga_green = rgb_r[15:8];
  assign out_vga_blue  = rgb_r[7:0];
  assign out_vga_blank = blank_r;
  assign out_vga_hsync = hsync_r;
  assign out_vga_vsync = vsync_r;
  assign frame_start   = frame_start_r;
  assign underflow_cnt = underflow_r;

endmodule

// File: doc/vga_stream_timing.md
VGA_STREAM_TIMING -- requirements
Module: vga_stream_timing

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, default 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, default 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter SYNC_ACTIVE, default 0, level of hsync/vsync during the sync pulse.
REQ-006 Parameter UNDERFLOW_RGB, default 24'hFF00FF, colour driven on a missed pixel.
REQ-007 pclk  input  1  pixel clock; the only clock in the block.
REQ-008 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-009 enable  input  1  request to stream frames.
REQ-010 pix_data  input  16  RGB565 pixel from the upstream frame FIFO.
REQ-011 pix_valid  input  1  pix_data is valid.
REQ-012 pix_ready  output  1  block consumes pix_data this cycle.
REQ-013 out_vga_red / out_vga_green / out_vga_blue  output  8 each  pixel colour to the HDMI device.
REQ-014 out_vga_blank / out_vga_hsync / out_vga_vsync  output  1 each  timing to the HDMI device.
REQ-015 frame_start  output  1  one-cycle pulse aligned with the first output pixel of a frame.
REQ-016 underflow_cnt  output  16  saturating count of missed pixels.

Function
REQ-017 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the horizontal parameters, 800 by default) and wrap to 0; v_cnt SHALL increment when h_cnt wraps, count 0..V_TOTAL-1 (525 by default) and wrap.
REQ-018 Active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync SHALL equal SYNC_ACTIVE for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, with vsync defined analogously on v_cnt.
REQ-019 Every output SHALL be registered, carrying the values derived from the counter state one pclk earlier, for a fixed latency of 1 cycle.
REQ-020 FSM states SHALL be SYNC_WAIT and RUN, with SYNC_WAIT as the reset state.
REQ-021 SYNC_WAIT->RUN SHALL occur when the counter is at (0,0) and enable=1; RUN->SYNC_WAIT SHALL occur only at (H_TOTAL-1, V_TOTAL-1) with enable=0, so a deassert mid-frame completes the frame.
REQ-022 pix_ready SHALL be combinational: 1 only in RUN and in the active region.
REQ-023 A transfer SHALL occur on pix_ready & pix_valid, and the expanded colour SHALL be registered: red={R5,R5[4:2]}, green={G6,G6[5:4]}, blue={B5,B5[4:2]}.
REQ-024 When pix_ready=1 and pix_valid=0, the block SHALL output UNDERFLOW_RGB, keep the pixel slot and timing unchanged (no stall), and increment underflow_cnt, saturating at 16'hFFFF.
REQ-025 In SYNC_WAIT, sync outputs SHALL still toggle per the counters, blank SHALL be 1, RGB SHALL be 0, and pix_data SHALL be ignored.
REQ-026 During blanking, RGB SHALL be 0.
REQ-027 frame_start SHALL pulse only in RUN, for the pixel at counter (0,0).

Reset
REQ-028 While rst_n=0: counters at (0,0), state SYNC_WAIT, RGB=0, blank=1, hsync=vsync=~SYNC_ACTIVE, frame_start=0, underflow_cnt=0.
REQ-029 Release of rst_n SHALL be synchronised internally with a two-flop synchroniser; the counters SHALL start on the first pclk after the synchronised release.
REQ-030 An asserted reset mid-frame SHALL immediately force the reset values; no partial frame SHALL resume afterwards.

Structure
REQ-031 A shared package SHALL hold the 640x480@60 timing constants, the state encoding, and the RGB565 field positions.
REQ-032 One sub-module SHALL exist: vga_timing_counter (h/v counters plus active/sync decode); the FSM, handshake and colour path SHALL remain in the top level.

Verification
REQ-033 Reset then enable=1 with pix_valid held 1: the first frame_start occurs at (0,0) of the first full frame, 640 pix_ready cycles per line, 307200 per frame, underflow_cnt=0.
REQ-034 pix_data=16'hF800 on an active cycle -> next cycle RGB=FF/00/00, blank=0; pix_data=16'h07E0 -> 00/FF/00.
REQ-035 hsync low exactly 96 cycles starting at h_cnt=656; vsync low exactly 2 lines starting at line 490; line period 800, frame period 420000 cycles.
REQ-036 pix_valid=0 for 5 active cycles -> 5 pixels output as FF00FF, underflow_cnt=5, and the next frame_start stays at the same period.
REQ-037 enable dropped at line 100 -> the frame completes, pix_ready stays 0 from the next (0,0), blank stays 1, and syncs continue.
REQ-038 rst_n asserted at pixel (300,200) -> all outputs take their reset values asynchronously, and after release the frame timing restarts from (0,0).
